// File: rtl/counter_sched.sv
// Two-requester round-robin scheduler around one shared up-counter.
// A granted run loads init and counts by one until it reaches end.
module counter_sched #(
  parameter int unsigned Width = 32
) (
  input  logic             Clk_i,
  input  logic             Reset_n_i,
  input  logic [1:0]       Req_i,
  input  logic [Width-1:0] ReqInit0_i,
  input  logic [Width-1:0] ReqEnd0_i,
  input  logic [Width-1:0] ReqInit1_i,
  input  logic [Width-1:0] ReqEnd1_i,
  input  logic             Abort_i,
  output logic [1:0]       Grant_o,
  output logic [1:0]       Done_o,
  output logic [1:0]       Err_o,
  output logic             Busy_o,
  output logic             Owner_o,
  output logic [Width-1:0] Data_o
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] data_q, data_d;
  logic [Width-1:0] end_q, end_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       err_q, err_d;

  logic             win;
  logic [Width-1:0] win_init;
  logic [Width-1:0] win_end;

  // ptr_q names the requester that wins a tie
  always_comb begin
    win      = (Req_i == 2'b11) ? ptr_q : Req_i[1];
    win_init = win ? ReqInit1_i : ReqInit0_i;
    win_end  = win ? ReqEnd1_i : ReqEnd0_i;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    end_d   = end_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    done_d  = '0;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (Req_i != 2'b00) begin
          ptr_d = ~win;
          if (win_init <= win_end) begin
            grant_d[win] = 1'b1;
            data_d       = win_init;
            end_d        = win_end;
            owner_d      = win;
            state_d      = COUNT;
          end else begin
            err_d[win] = 1'b1;
          end
        end
      end
      COUNT: begin
        if (Abort_i) begin
          state_d = IDLE;
        end else if (data_q == end_q) begin
          state_d         = DONE;
          done_d[owner_q] = 1'b1;
        end else begin
          data_d = data_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      end_q   <= '0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      end_q   <= end_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Grant_o = grant_q;
  assign Done_o  = done_q;
  assign Err_o   = err_q;
  assign Busy_o  = (state_q != IDLE);
  assign Owner_o = owner_q;
  assign Data_o  = data_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched: arbitration, counting, abort,
// degenerate bounds, 8-bit boundary and asynchronous reset.
module tb_counter_sched;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] init0, end0, init1, end1;
  logic        abort;
  logic [1:0]  grant, done, err;
  logic        busy, owner;
  logic [31:0] data;

  logic [1:0]  req8;
  logic [7:0]  init8, end8;
  logic [1:0]  grant8, done8, err8;
  logic        busy8, owner8;
  logic [7:0]  data8;

  int n_tests = 0;
  int n_fail  = 0;

  counter_sched #(.Width(32)) u_dut (
    .Clk_i      (clk),
    .Reset_n_i  (rst_n),
    .Req_i      (req),
    .ReqInit0_i (init0),
    .ReqEnd0_i  (end0),
    .ReqInit1_i (init1),
    .ReqEnd1_i  (end1),
    .Abort_i    (abort),
    .Grant_o    (grant),
    .Done_o     (done),
    .Err_o      (err),
    .Busy_o     (busy),
    .Owner_o    (owner),
    .Data_o     (data)
  );

  counter_sched #(.Width(8)) u_dut8 (
    .Clk_i      (clk),
    .Reset_n_i  (rst_n),
    .Req_i      (req8),
    .ReqInit0_i (init8),
    .ReqEnd0_i  (end8),
    .ReqInit1_i (8'd0),
    .ReqEnd1_i  (8'd0),
    .Abort_i    (1'b0),
    .Grant_o    (grant8),
    .Done_o     (done8),
    .Err_o      (err8),
    .Busy_o     (busy8),
    .Owner_o    (owner8),
    .Data_o     (data8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] g,
                      input logic [1:0] dn, input logic [1:0] er,
                      input logic b, input logic [31:0] dat);
    @(negedge clk);
    chk({tag, " grant"}, {30'd0, grant}, {30'd0, g});
    chk({tag, " done"}, {30'd0, done}, {30'd0, dn});
    chk({tag, " err"}, {30'd0, err}, {30'd0, er});
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, " data"}, data, dat);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    init0 = '0; end0 = '0;
    init1 = '0; end1 = '0;
    abort = 1'b0;
    req8  = 2'b00;
    init8 = '0; end8 = '0;

    #1;
    chk("rst data", data, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst owner", {31'd0, owner}, 32'd0);
    chk("rst pulses", {26'd0, grant, done, err}, 32'd0);

    // single run 8..64
    @(negedge clk);
    rst_n = 1'b1;
    req   = 2'b01; init0 = 32'd8; end0 = 32'd64;
    step("single grant", 2'b01, 2'b00, 2'b00, 1'b1, 32'd8);
    req = 2'b00;
    for (int k = 9; k <= 64; k++)
      step("single count", 2'b00, 2'b00, 2'b00, 1'b1, k);
    step("single done", 2'b00, 2'b01, 2'b00, 1'b1, 32'd64);
    step("single idle", 2'b00, 2'b00, 2'b00, 1'b0, 32'd64);

    // contention from reset
    rst_n = 1'b0;
    req   = 2'b11;
    init0 = 32'd0;  end0 = 32'd3;
    init1 = 32'd10; end1 = 32'd12;
    @(negedge clk);
    rst_n = 1'b1;
    step("cont g0", 2'b01, 2'b00, 2'b00, 1'b1, 32'd0);
    chk("cont owner0", {31'd0, owner}, 32'd0);
    for (int k = 1; k <= 3; k++)
      step("cont c0", 2'b00, 2'b00, 2'b00, 1'b1, k);
    step("cont d0", 2'b00, 2'b01, 2'b00, 1'b1, 32'd3);
    step("cont idle0", 2'b00, 2'b00, 2'b00, 1'b0, 32'd3);
    step("cont g1", 2'b10, 2'b00, 2'b00, 1'b1, 32'd10);
    chk("cont owner1", {31'd0, owner}, 32'd1);
    step("cont c1", 2'b00, 2'b00, 2'b00, 1'b1, 32'd11);
    step("cont c1", 2'b00, 2'b00, 2'b00, 1'b1, 32'd12);
    step("cont d1", 2'b00, 2'b10, 2'b00, 1'b1, 32'd12);
    step("cont idle1", 2'b00, 2'b00, 2'b00, 1'b0, 32'd12);
    step("cont g0b", 2'b01, 2'b00, 2'b00, 1'b1, 32'd0);
    req = 2'b00;
    for (int k = 1; k <= 3; k++)
      step("cont c0b", 2'b00, 2'b00, 2'b00, 1'b1, k);
    step("cont d0b", 2'b00, 2'b01, 2'b00, 1'b1, 32'd3);
    step("cont idle2", 2'b00, 2'b00, 2'b00, 1'b0, 32'd3);

    // init == end
    req = 2'b01; init0 = 32'd5; end0 = 32'd5;
    step("eq grant", 2'b01, 2'b00, 2'b00, 1'b1, 32'd5);
    req = 2'b00;
    step("eq done", 2'b00, 2'b01, 2'b00, 1'b1, 32'd5);
    step("eq idle", 2'b00, 2'b00, 2'b00, 1'b0, 32'd5);

    // rejects rotate the pointer
    req = 2'b10; init1 = 32'd7; end1 = 32'd6;
    step("err1", 2'b00, 2'b00, 2'b10, 1'b0, 32'd5);
    req = 2'b11;
    init0 = 32'd7; end0 = 32'd6;
    init1 = 32'd2; end1 = 32'd2;
    step("err0", 2'b00, 2'b00, 2'b01, 1'b0, 32'd5);
    req = 2'b10;
    step("rot g1", 2'b10, 2'b00, 2'b00, 1'b1, 32'd2);
    req = 2'b00;
    step("rot d1", 2'b00, 2'b10, 2'b00, 1'b1, 32'd2);
    step("rot idle", 2'b00, 2'b00, 2'b00, 1'b0, 32'd2);

    // abort at 20 with requester 1 pending
    req = 2'b01; init0 = 32'd0; end0 = 32'd100;
    step("ab grant", 2'b01, 2'b00, 2'b00, 1'b1, 32'd0);
    req = 2'b10; init1 = 32'd50; end1 = 32'd52;
    for (int k = 1; k <= 20; k++)
      step("ab count", 2'b00, 2'b00, 2'b00, 1'b1, k);
    abort = 1'b1;
    step("ab idle", 2'b00, 2'b00, 2'b00, 1'b0, 32'd20);
    abort = 1'b0;
    step("ab g1", 2'b10, 2'b00, 2'b00, 1'b1, 32'd50);
    req = 2'b00;
    step("ab c1", 2'b00, 2'b00, 2'b00, 1'b1, 32'd51);
    step("ab c1", 2'b00, 2'b00, 2'b00, 1'b1, 32'd52);
    step("ab d1", 2'b00, 2'b10, 2'b00, 1'b1, 32'd52);
    step("ab idle2", 2'b00, 2'b00, 2'b00, 1'b0, 32'd52);

    // 8-bit run ending at all-ones
    req8 = 2'b01; init8 = 8'd250; end8 = 8'd255;
    @(negedge clk);
    chk("w8 grant", {30'd0, grant8}, 32'd1);
    chk("w8 data0", {24'd0, data8}, 32'd250);
    req8 = 2'b00;
    for (int k = 251; k <= 255; k++) begin
      @(negedge clk);
      chk("w8 count", {24'd0, data8}, k);
    end
    @(negedge clk);
    chk("w8 done", {30'd0, done8}, 32'd1);
    chk("w8 hold", {24'd0, data8}, 32'd255);
    @(negedge clk);
    chk("w8 busy", {31'd0, busy8}, 32'd0);
    chk("w8 nowrap", {24'd0, data8}, 32'd255);
    chk("w8 err", {30'd0, err8}, 32'd0);

    // async reset mid-count
    req = 2'b01; init0 = 32'd25; end0 = 32'd40;
    step("ar grant", 2'b01, 2'b00, 2'b00, 1'b1, 32'd25);
    req = 2'b00;
    for (int k = 26; k <= 30; k++)
      step("ar count", 2'b00, 2'b00, 2'b00, 1'b1, k);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar data", data, 32'd0);
    chk("ar busy", {31'd0, busy}, 32'd0);
    chk("ar pulses", {26'd0, grant, done, err}, 32'd0);
    chk("ar owner", {31'd0, owner}, 32'd0);
    @(negedge clk);
    req   = 2'b11;
    init0 = 32'd3; end0 = 32'd4;
    init1 = 32'd9; end1 = 32'd9;
    rst_n = 1'b1;
    step("ar g0", 2'b01, 2'b00, 2'b00, 1'b1, 32'd3);
    chk("ar owner0", {31'd0, owner}, 32'd0);
    req = 2'b00;
    step("ar c0", 2'b00, 2'b00, 2'b00, 1'b1, 32'd4);
    step("ar d0", 2'b00, 2'b01, 2'b00, 1'b1, 32'd4);
    step("ar idle", 2'b00, 2'b00, 2'b00, 1'b0, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
